hamming_encode_sched: RTL and testbench

- Round-robin scheduler sharing one 72/64 SECDED Hamming encoder datapath between two 64-bit requesters.
- Accepts a data word through a valid/ready handshake and holds it stable on the encoder input.
- Issues a one-cycle encode strobe, waits a fixed encoder latency, captures the 72-bit codeword, and presents it downstream on a valid/ready handshake tagged with its source.
- Sits between the data-producing front ends and the encoder / storage write path.

---
 rtl/hamming_pkg.sv | 28 ++
 rtl/rr_arbiter2.sv | 23 ++
 rtl/hamming_encode_sched.sv | 141 ++++++++++++++
 tb/tb_hamming_encode_sched.sv | 426 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hamming_pkg.sv
// Shared types and constants for the two-requester SECDED (72/64) encode scheduler.
// Codeword layout: bit 0 is the overall parity bit; the Hamming parity bits sit at the power-of-two positions.
package hamming_pkg;

    localparam int DATA_W = 64;
    localparam int CODE_W = 72;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        OUT   = 2'd3
    } sched_state_t;

    localparam int N_PARITY = 7;
    localparam logic [6:0] PARITY_POS [N_PARITY] = '{7'd1, 7'd2, 7'd4, 7'd8, 7'd16, 7'd32, 7'd64};

    // True when a codeword bit position carries a Hamming parity bit rather than data.
    function automatic logic is_parity_pos(input logic [6:0] pos);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < N_PARITY; i++) begin
            hit = hit | (pos == PARITY_POS[i]);
        end
        return hit;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational two-way round-robin grant: a lone requester wins outright,
// and under contention the requester that did not win last time is chosen.
module rr_arbiter2 (
    input  logic valid0,
    input  logic valid1,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant_id
);

    // Grant selection from the request pair and the previous winner.
    always_comb begin
        grant_valid = valid0 | valid1;
        grant_id    = 1'b0;
        case ({valid1, valid0})
            2'b01:   grant_id = 1'b0;
            2'b10:   grant_id = 1'b1;
            2'b11:   grant_id = ~last_grant;
            default: grant_id = 1'b0;
        endcase
    end

endmodule

// File: rtl/hamming_encode_sched.sv
// Shares one external 72/64 SECDED encoder between two 64-bit requesters: accept, strobe,
// wait a fixed encoder latency, capture, then present the tagged codeword downstream.
module hamming_encode_sched
    import hamming_pkg::*;
#(
    parameter int ENC_LATENCY = 1,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    output logic [DATA_W-1:0] enc_data,
    output logic              enc_start,
    input  logic [CODE_W-1:0] enc_codeword,
    output logic              out_valid,
    output logic [CODE_W-1:0] out_codeword,
    output logic              out_src,
    input  logic              out_ready,
    output logic              busy,
    output logic [CNT_W-1:0]  word_count
);

    localparam int WAIT_W = ($clog2(ENC_LATENCY + 1) < 1) ? 1 : $clog2(ENC_LATENCY + 1);
    localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(ENC_LATENCY - 1);

    sched_state_t      state_r;
    logic              last_grant_r;
    logic [WAIT_W-1:0] wait_cnt_r;
    logic [DATA_W-1:0] enc_data_r;
    logic              enc_start_r;
    logic              out_valid_r;
    logic [CODE_W-1:0] out_codeword_r;
    logic              out_src_r;
    logic              busy_r;
    logic [CNT_W-1:0]  word_count_r;

    logic grant_valid_s;
    logic grant_id_s;
    logic accept_s;
    logic handshake_s;

    rr_arbiter2 u_arb (
        .valid0      (req0_valid),
        .valid1      (req1_valid),
        .last_grant  (last_grant_r),
        .grant_valid (grant_valid_s),
        .grant_id    (grant_id_s)
    );

    // Ready is only offered in IDLE, and only to the granted requester.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        if ((state_r == IDLE) && grant_valid_s) begin
            req0_ready = ~grant_id_s;
            req1_ready = grant_id_s;
        end else begin
            req0_ready = 1'b0;
            req1_ready = 1'b0;
        end
    end

    assign accept_s    = req0_ready | req1_ready;
    assign handshake_s = out_valid_r & out_ready;

    // Scheduler state machine; every output it drives is registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r        <= IDLE;
            last_grant_r   <= 1'b1;
            wait_cnt_r     <= {WAIT_W{1'b0}};
            enc_data_r     <= {DATA_W{1'b0}};
            enc_start_r    <= 1'b0;
            out_valid_r    <= 1'b0;
            out_codeword_r <= {CODE_W{1'b0}};
            out_src_r      <= 1'b0;
            busy_r         <= 1'b0;
            word_count_r   <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        enc_data_r   <= grant_id_s ? req1_data : req0_data;
                        out_src_r    <= grant_id_s;
                        last_grant_r <= grant_id_s;
                        enc_start_r  <= 1'b1;
                        busy_r       <= 1'b1;
                        state_r      <= ISSUE;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ISSUE: begin
                    enc_start_r <= 1'b0;
                    wait_cnt_r  <= WAIT_LOAD;
                    state_r     <= WAIT;
                end
                WAIT: begin
                    // Counter reaching zero marks the cycle the encoder result is final.
                    if (wait_cnt_r == {WAIT_W{1'b0}}) begin
                        out_codeword_r <= enc_codeword;
                        out_valid_r    <= 1'b1;
                        state_r        <= OUT;
                    end else begin
                        wait_cnt_r <= wait_cnt_r - WAIT_W'(1);
                    end
                end
                OUT: begin
                    if (handshake_s) begin
                        out_valid_r  <= 1'b0;
                        busy_r       <= 1'b0;
                        word_count_r <= word_count_r + CNT_W'(1);
                        state_r      <= IDLE;
                    end else begin
                        state_r <= OUT;
                    end
                end
                default: begin
                    enc_start_r <= 1'b0;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign enc_data     = enc_data_r;
    assign enc_start    = enc_start_r;
    assign out_valid    = out_valid_r;
    assign out_codeword = out_codeword_r;
    assign out_src      = out_src_r;
    assign busy         = busy_r;
    assign word_count   = word_count_r;

endmodule

// File: tb/tb_hamming_encode_sched.sv
// Directed bench for hamming_encode_sched: three instances (latency 1, latency 4, 2-bit counter)
// share stimulus; each scenario task resets and checks one instance against hand-derived values.
module tb_hamming_encode_sched;

    logic        clk;
    logic        rst;
    logic        req0_valid;
    logic [63:0] req0_data;
    logic        req1_valid;
    logic [63:0] req1_data;
    logic        out_ready;

    logic        a_r0rdy, a_r1rdy, a_start, a_ov, a_src, a_busy;
    logic [63:0] a_edata;
    logic [71:0] a_cw, a_ocw;
    logic [15:0] a_cnt;

    logic        b_r0rdy, b_r1rdy, b_start, b_ov, b_src, b_busy;
    logic [63:0] b_edata;
    logic [71:0] b_cw, b_ocw;
    logic [15:0] b_cnt;

    logic        c_r0rdy, c_r1rdy, c_start, c_ov, c_src, c_busy;
    logic [63:0] c_edata;
    logic [71:0] c_cw, c_ocw;
    logic [1:0]  c_cnt;

    int tests_run;
    int tests_failed;

    // Reference SECDED encoder: data fills non-power-of-two positions 3..71 in order.
    function automatic logic [71:0] enc_model(input logic [63:0] d);
        logic [71:0] cw;
        logic        p;
        int          di;
        cw = 72'd0;
        di = 0;
        for (int pos = 1; pos < 72; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                cw[pos] = d[di];
                di++;
            end
        end
        for (int k = 0; k < 7; k++) begin
            p = 1'b0;
            for (int pos = 1; pos < 72; pos++) begin
                if ((((pos >> k) & 1) == 1) && (pos != (1 << k))) p = p ^ cw[pos];
            end
            cw[1 << k] = p;
        end
        cw[0] = ^cw[71:1];
        return cw;
    endfunction

    assign a_cw = enc_model(a_edata);
    assign b_cw = enc_model(b_edata);
    assign c_cw = enc_model(c_edata);

    hamming_encode_sched #(.ENC_LATENCY(1), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(a_r0rdy),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(a_r1rdy),
        .enc_data(a_edata), .enc_start(a_start), .enc_codeword(a_cw),
        .out_valid(a_ov), .out_codeword(a_ocw), .out_src(a_src), .out_ready(out_ready),
        .busy(a_busy), .word_count(a_cnt)
    );

    hamming_encode_sched #(.ENC_LATENCY(4), .CNT_W(16)) dut_b (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(b_r0rdy),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(b_r1rdy),
        .enc_data(b_edata), .enc_start(b_start), .enc_codeword(b_cw),
        .out_valid(b_ov), .out_codeword(b_ocw), .out_src(b_src), .out_ready(out_ready),
        .busy(b_busy), .word_count(b_cnt)
    );

    hamming_encode_sched #(.ENC_LATENCY(1), .CNT_W(2)) dut_c (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(c_r0rdy),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(c_r1rdy),
        .enc_data(c_edata), .enc_start(c_start), .enc_codeword(c_cw),
        .out_valid(c_ov), .out_codeword(c_ocw), .out_src(c_src), .out_ready(out_ready),
        .busy(c_busy), .word_count(c_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        tests_run++;
        if ({a_ov, a_start, a_busy, a_src, a_r0rdy, a_r1rdy} !== 6'b000000) begin
            tests_failed++;
            $display("FAIL reset_flags: got %b expected 000000", {a_ov, a_start, a_busy, a_src, a_r0rdy, a_r1rdy});
        end
        tests_run++;
        if ({a_edata, a_ocw, a_cnt} !== 152'd0) begin
            tests_failed++;
            $display("FAIL reset_values: got edata=%h ocw=%h cnt=%0d expected all 0", a_edata, a_ocw, a_cnt);
        end
        rst = 1'b0;
        @(negedge clk);
        req0_valid = 1'b1;
        req0_data  = 64'h5;
        req1_valid = 1'b1;
        req1_data  = 64'h6;
        #1;
        tests_run++;
        if ({a_r0rdy, a_r1rdy} !== 2'b10) begin
            tests_failed++;
            $display("FAIL reset_first_grant: got r0=%b r1=%b expected r0=1 r1=0", a_r0rdy, a_r1rdy);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        @(negedge clk);
        req0_valid = 1'b1;
        req0_data  = 64'h1;
        #1;
        tests_run++;
        if ({a_r0rdy, a_r1rdy} !== 2'b10) begin
            tests_failed++;
            $display("FAIL single_ready_c0: got r0=%b r1=%b expected r0=1 r1=0", a_r0rdy, a_r1rdy);
        end
        @(negedge clk);
        req0_valid = 1'b0;
        tests_run++;
        if ({a_start, a_busy, a_edata} !== {2'b11, 64'h1}) begin
            tests_failed++;
            $display("FAIL single_start_c1: got start=%b busy=%b edata=%h expected 1 1 1", a_start, a_busy, a_edata);
        end
        @(negedge clk);
        tests_run++;
        if ({a_start, a_ov} !== 2'b00) begin
            tests_failed++;
            $display("FAIL single_wait_c2: got start=%b ov=%b expected 0 0", a_start, a_ov);
        end
        @(negedge clk);
        tests_run++;
        if ({a_ov, a_src, a_ocw} !== {1'b1, 1'b0, 72'h0F}) begin
            tests_failed++;
            $display("FAIL single_out_c3: got ov=%b src=%b cw=%h expected 1 0 f", a_ov, a_src, a_ocw);
        end
        @(negedge clk);
        tests_run++;
        if ({a_cnt, a_ov, a_busy} !== {16'd1, 2'b00}) begin
            tests_failed++;
            $display("FAIL single_count_c4: got cnt=%0d ov=%b busy=%b expected 1 0 0", a_cnt, a_ov, a_busy);
        end
    endtask

    task automatic test_contention();
        int grants[8];
        int srcs[4];
        logic [71:0] cws[4];
        int ng;
        int no;
        ng = 0;
        no = 0;
        do_reset();
        @(negedge clk);
        req0_valid = 1'b1;
        req0_data  = 64'hA0;
        req1_valid = 1'b1;
        req1_data  = 64'hB0;
        for (int c = 0; c < 40 && no < 4; c++) begin
            #1;
            if (a_r0rdy && ng < 8) begin grants[ng] = 0; ng++; end
            if (a_r1rdy && ng < 8) begin grants[ng] = 1; ng++; end
            if (a_ov && out_ready) begin
                srcs[no] = a_src;
                cws[no]  = a_ocw;
                no++;
            end
            if (no < 4) @(negedge clk);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tests_run++;
        if (no != 4 || ng != 4) begin
            tests_failed++;
            $display("FAIL contention_count: got outputs=%0d grants=%0d expected 4 4", no, ng);
        end
        for (int i = 0; i < 4; i++) begin
            if (i < ng && i < no) begin
                tests_run++;
                if (grants[i] != (i % 2) || srcs[i] != (i % 2)) begin
                    tests_failed++;
                    $display("FAIL contention_order[%0d]: got grant=%0d src=%0d expected %0d", i, grants[i], srcs[i], i % 2);
                end
                tests_run++;
                if (cws[i] !== enc_model((i % 2) == 1 ? 64'hB0 : 64'hA0)) begin
                    tests_failed++;
                    $display("FAIL contention_cw[%0d]: got %h expected %h", i, cws[i],
                             enc_model((i % 2) == 1 ? 64'hB0 : 64'hA0));
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [71:0] held;
        int waited;
        waited = 0;
        do_reset();
        out_ready = 1'b0;
        @(negedge clk);
        req0_valid = 1'b1;
        req0_data  = 64'h8000_0000_0000_0000;
        req1_valid = 1'b1;
        req1_data  = 64'h3;
        while (!a_ov && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        held = a_ocw;
        tests_run++;
        if (!a_ov || held !== 72'h81_0000_0000_0000_0017) begin
            tests_failed++;
            $display("FAIL bp_first_cw: got ov=%b cw=%h expected 1 810000000000000017", a_ov, held);
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            tests_run++;
            if ({a_ov, a_r0rdy, a_r1rdy, a_ocw, a_cnt} !== {3'b100, 72'h81_0000_0000_0000_0017, 16'd0}) begin
                tests_failed++;
                $display("FAIL bp_hold[%0d]: got ov=%b r0=%b r1=%b cw=%h cnt=%0d expected 1 0 0 held 0",
                         c, a_ov, a_r0rdy, a_r1rdy, a_ocw, a_cnt);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({a_cnt, a_ov, a_r1rdy, a_r0rdy} !== {16'd1, 3'b010}) begin
            tests_failed++;
            $display("FAIL bp_release: got cnt=%0d ov=%b r1=%b r0=%b expected 1 0 1 0", a_cnt, a_ov, a_r1rdy, a_r0rdy);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        tests_run++;
        if (a_cnt !== 16'd1) begin
            tests_failed++;
            $display("FAIL bp_single_handshake: got cnt=%0d expected 1", a_cnt);
        end
    endtask

    task automatic test_latency();
        int start_cyc;
        int nstart;
        int first_v;
        logic [71:0] cw;
        start_cyc = -1;
        nstart = 0;
        first_v = -1;
        cw = 72'd0;
        do_reset();
        @(negedge clk);
        req0_valid = 1'b1;
        req0_data  = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        tests_run++;
        if (b_r0rdy !== 1'b1) begin
            tests_failed++;
            $display("FAIL lat_accept: got %b expected 1", b_r0rdy);
        end
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (c == 1) req0_valid = 1'b0;
            if (b_start) begin
                nstart++;
                if (start_cyc < 0) start_cyc = c;
            end
            if (b_ov && first_v < 0) begin
                first_v = c;
                cw = b_ocw;
            end
        end
        tests_run++;
        if (start_cyc != 1 || nstart != 1) begin
            tests_failed++;
            $display("FAIL lat_start: got cycle=%0d pulses=%0d expected 1 1", start_cyc, nstart);
        end
        tests_run++;
        if (first_v != 6) begin
            tests_failed++;
            $display("FAIL lat_out_valid: got cycle %0d expected 6", first_v);
        end
        tests_run++;
        if (cw !== 72'hFF_FFFF_FFFF_FFFF_FFFF) begin
            tests_failed++;
            $display("FAIL lat_codeword: got %h expected ffffffffffffffffff", cw);
        end
    endtask

    task automatic test_reset_mid_wait();
        int waited;
        waited = 0;
        do_reset();
        @(negedge clk);
        req0_valid = 1'b1;
        req0_data  = 64'h1234;
        @(negedge clk);
        req0_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        tests_run++;
        if ({b_busy, b_ov} !== 2'b10) begin
            tests_failed++;
            $display("FAIL rmw_in_wait: got busy=%b ov=%b expected 1 0", b_busy, b_ov);
        end
        rst = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({b_busy, b_ov, b_start, b_cnt} !== {3'b000, 16'd0}) begin
            tests_failed++;
            $display("FAIL rmw_after_reset: got busy=%b ov=%b start=%b cnt=%0d expected 0 0 0 0", b_busy, b_ov, b_start, b_cnt);
        end
        rst = 1'b0;
        @(negedge clk);
        req1_valid = 1'b1;
        req1_data  = 64'h77;
        #1;
        tests_run++;
        if ({b_r0rdy, b_r1rdy} !== 2'b01) begin
            tests_failed++;
            $display("FAIL rmw_req1_grant: got r0=%b r1=%b expected 0 1", b_r0rdy, b_r1rdy);
        end
        @(negedge clk);
        req1_valid = 1'b0;
        while (!b_ov && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        tests_run++;
        if ({b_ov, b_src} !== 2'b11) begin
            tests_failed++;
            $display("FAIL rmw_out: got ov=%b src=%b expected 1 1", b_ov, b_src);
        end
        @(negedge clk);
        tests_run++;
        if (b_cnt !== 16'd1) begin
            tests_failed++;
            $display("FAIL rmw_count: got %0d expected 1", b_cnt);
        end
    endtask

    task automatic test_wrap();
        logic [1:0] seen[5];
        logic [1:0] expv[5];
        logic [1:0] prev;
        int n;
        expv[0] = 2'd1; expv[1] = 2'd2; expv[2] = 2'd3; expv[3] = 2'd0; expv[4] = 2'd1;
        n = 0;
        do_reset();
        prev = c_cnt;
        @(negedge clk);
        req0_valid = 1'b1;
        req0_data  = 64'h42;
        for (int c = 0; c < 60 && n < 5; c++) begin
            @(negedge clk);
            if (c_cnt != prev) begin
                seen[n] = c_cnt;
                prev = c_cnt;
                n++;
            end
        end
        req0_valid = 1'b0;
        tests_run++;
        if (n != 5) begin
            tests_failed++;
            $display("FAIL wrap_words: got %0d count changes expected 5", n);
        end
        for (int i = 0; i < 5; i++) begin
            if (i < n) begin
                tests_run++;
                if (seen[i] !== expv[i]) begin
                    tests_failed++;
                    $display("FAIL wrap_value[%0d]: got %0d expected %0d", i, seen[i], expv[i]);
                end
            end
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        req0_valid   = 1'b0;
        req0_data    = 64'd0;
        req1_valid   = 1'b0;
        req1_data    = 64'd0;
        out_ready    = 1'b1;
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_latency();
        test_reset_mid_wait();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
